spi_flash_arb: RTL
==================

// Module: spi_flash_arb
// PURPOSE
//  Shares the configuration SPI flash between two byte-read requesters: port 0 (boot ROM loader,
//  high priority) and port 1 (runtime reader, e.g. magic-menu/ROM patch fetch). Sequences SPI
//  mode-0 READ (0x03 + 24-bit address) transactions on clk168 and keeps CS asserted between
//  consecutive addresses so sequential streams cost 8 SCK periods per byte.
// PARAMETERS
//  CLK_DIV       4     SCK half-period in clk168 cycles (4 -> 21 MHz SCK); >=2
//  CS_GAP        8     minimum clk168 cycles flash_cs_n stays high between transactions
//  HOLD_TIMEOUT  255   clk168 cycles CS held low in HOLD waiting for a continuation
// PORTS
//  clk168      in   1   system clock, 168 MHz
//  rst_n       in   1   reset, asynchronous, active-low
//  req0/req1   in   1   read request, level; held with addr stable until ack
//  addr0/addr1 in   24  byte address
//  ack0/ack1   out  1   one-cycle pulse: request accepted, req may drop/addr change
//  data0/data1 out  8   read byte, valid only while validN=1
//  valid0/1    out  1   one-cycle pulse: byte returned
//  busy        out  1   high whenever state != IDLE
//  flash_cs_n  out  1   flash chip select
//  flash_sck   out  1   SPI clock, idle low (mode 0)
//  flash_mosi  out  1   changes on SCK fall/CS fall, MSB first
//  flash_miso  in   1   sampled on SCK rise
// BEHAVIOUR
//  Reset (async): state IDLE, cs_n=1, sck=0, mosi=0, ack*=0, valid*=0, data*=0, busy=0, owner=0.
//  States: IDLE, CMD(8b), ADDR(24b), DATA(8b), HOLD, DESEL.
//  IDLE: req0 wins over req1 when both high. Same cycle: ackN=1, latch addr, owner=N -> CMD.
//  Bit timing: cycle after ack cs_n=0, mosi=bit; SCK low CLK_DIV cycles, high CLK_DIV cycles;
//   rise k (0-based within transaction) at ack+1+CLK_DIV*(2k+1).
//  New transaction: 40 bits; validN=1 and dataN at ack+2+79*CLK_DIV (=318 @CLK_DIV=4).
//  DATA done -> HOLD, SCK low, CS low, last_addr=latched addr.
//  HOLD, owner req high, addr==last_addr+1 (mod 2^24), other req low: ack, -> DATA only;
//   valid at ack+2+15*CLK_DIV (=62).
//  HOLD, any other case (owner non-sequential, other requester pending, timer hits
//   HOLD_TIMEOUT): -> DESEL; cs_n=1 next cycle. No ack issued from HOLD in this case.
//  DESEL: cs_n=1 for exactly CS_GAP cycles, then IDLE (arbitration re-evaluated there).
//  Requester may drop req before ack (withdrawn, no side effect). No preemption mid-byte.
//  Only owner's ack/valid/data pulse; other port's outputs stay 0.
//  ack and valid never in same cycle for a port; valid precedes next ack of same port.
//  Timeout counter clears on each HOLD entry; saturates, no wrap.
//  Bit/clock counters wrap internally; address increment wraps 0xFFFFFF -> 0x000000.
// TESTING
//  Single read: req0 addr 0x013256, model byte 0xA5 -> MOSI 03 01 32 56, data0=0xA5,
//   valid0 at ack+318, cs_n high after DESEL.
//  Stream: req0 0x013256..0x013259 back-to-back -> one CS low period, valid spacing = 62+1
//   handshake cycles, 4 correct bytes.
//  Contention: req0,req1 same cycle -> ack0 first; ack1 only after cs_n high >= 8 cycles.
//  Fairness: owner 0 streaming with req1 pending in HOLD -> DESEL, port 1 served next.
//  Timeout: single read, no follow-up -> cs_n rises HOLD_TIMEOUT+1 cycles after valid.
//  Wrap + reset: continuation 0xFFFFFF->0x000000 stays in HOLD path; rst_n low mid-ADDR ->
//   cs_n=1, sck=0 immediately, next req starts fresh CMD.

Source files
------------

// File: rtl/spi_flash_arb_if.sv
// Requester-side bus for the SPI flash arbiter: two byte-read ports.
// The master modport is the requester side and the slave modport is the arbiter side.
interface spi_flash_arb_if;
  logic        req0;
  logic        req1;
  logic [23:0] addr0;
  logic [23:0] addr1;
  logic        ack0;
  logic        ack1;
  logic [7:0]  data0;
  logic [7:0]  data1;
  logic        valid0;
  logic        valid1;

  modport master (
    output req0, req1, addr0, addr1,
    input  ack0, ack1, data0, data1, valid0, valid1
  );

  modport slave (
    input  req0, req1, addr0, addr1,
    output ack0, ack1, data0, data1, valid0, valid1
  );
endinterface

// File: rtl/spi_flash_arb.sv
// SPI flash read arbiter. Two requesters share one mode-0 SPI flash using READ (0x03).
// Port 0 has priority. After a byte, CS stays low in HOLD so that a sequential follow-up
// from the same owner costs only 8 SCK periods. A pending request on the other port, a
// non-sequential owner request or the hold timeout all close the transaction. If port 0
// gives up HOLD because port 1 is waiting, port 1 wins the next arbitration.
module spi_flash_arb #(
  parameter int CLK_DIV      = 4,
  parameter int CS_GAP       = 8,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic             clk168,
  input  logic             rst_n,
  spi_flash_arb_if.slave   bus,
  output logic             busy,
  output logic             flash_cs_n,
  output logic             flash_sck,
  output logic             flash_mosi,
  input  logic             flash_miso
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;
  localparam int TMR_W = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(HOLD_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_HOLD  = 3'd4,
    S_DESEL = 3'd5
  } state_t;

  state_t             state_q;
  logic               owner_q;
  logic               yield1_q;
  logic               start_q;
  logic [DIV_W-1:0]   div_q;
  logic [4:0]         bit_q;
  logic [31:0]        tx_q;
  logic [7:0]         rx_q;
  logic [23:0]        addr_q;
  logic [23:0]        last_addr_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [GAP_W-1:0]   gap_q;
  logic               cs_n_q;
  logic               sck_q;
  logic               mosi_q;
  logic               busy_q;
  logic               ack0_q;
  logic               ack1_q;
  logic               valid0_q;
  logic               valid1_q;
  logic [7:0]         data0_q;
  logic [7:0]         data1_q;

  logic               owner_req_d;
  logic [23:0]        owner_addr_d;
  logic               other_req_d;
  logic               pick1_d;
  logic [23:0]        pick_addr_d;
  logic [23:0]        next_addr_d;
  logic               seq_hit_d;
  logic [7:0]         rx_byte_d;

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.valid0 = valid0_q;
  assign bus.valid1 = valid1_q;
  assign bus.data0  = data0_q;
  assign bus.data1  = data1_q;
  assign busy       = busy_q;
  assign flash_cs_n = cs_n_q;
  assign flash_sck  = sck_q;
  assign flash_mosi = mosi_q;

  assign next_addr_d = last_addr_q + 24'd1;
  assign seq_hit_d   = owner_req_d && (owner_addr_d == next_addr_d) && !other_req_d;
  assign rx_byte_d   = {rx_q[6:0], flash_miso};

  // Select the owner's and the other port's request view, and the IDLE arbitration winner.
  always_comb begin
    owner_req_d  = 1'b0;
    owner_addr_d = 24'd0;
    other_req_d  = 1'b0;
    pick1_d      = 1'b0;
    pick_addr_d  = 24'd0;
    if (owner_q) begin
      owner_req_d  = bus.req1;
      owner_addr_d = bus.addr1;
      other_req_d  = bus.req0;
    end else begin
      owner_req_d  = bus.req0;
      owner_addr_d = bus.addr0;
      other_req_d  = bus.req1;
    end
    if (bus.req1 && (!bus.req0 || yield1_q)) begin
      pick1_d     = 1'b1;
      pick_addr_d = bus.addr1;
    end else begin
      pick1_d     = 1'b0;
      pick_addr_d = bus.addr0;
    end
  end

  // Transaction FSM: arbitration, SPI bit sequencing, hold/continuation and CS gap.
  always_ff @(posedge clk168 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      yield1_q    <= 1'b0;
      start_q     <= 1'b0;
      div_q       <= '0;
      bit_q       <= 5'd0;
      tx_q        <= 32'd0;
      rx_q        <= 8'd0;
      addr_q      <= 24'd0;
      last_addr_q <= 24'd0;
      tmr_q       <= '0;
      gap_q       <= '0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      data0_q     <= 8'd0;
      data1_q     <= 8'd0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      data0_q  <= 8'd0;
      data1_q  <= 8'd0;

      case (state_q)
        S_IDLE: begin
          cs_n_q <= 1'b1;
          sck_q  <= 1'b0;
          mosi_q <= 1'b0;
          if (bus.req0 || bus.req1) begin
            owner_q  <= pick1_d;
            ack0_q   <= !pick1_d;
            ack1_q   <= pick1_d;
            addr_q   <= pick_addr_d;
            tx_q     <= {8'h03, pick_addr_d};
            bit_q    <= 5'd7;
            div_q    <= '0;
            start_q  <= 1'b1;
            yield1_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_CMD;
          end else begin
            busy_q <= 1'b0;
          end
        end

        S_CMD, S_ADDR, S_DATA: begin
          if (start_q) begin
            // Setup cycle after ack: assert CS and present the first bit.
            start_q <= 1'b0;
            cs_n_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= tx_q[31];
            div_q   <= '0;
          end else if (!sck_q) begin
            if (div_q == DIV_LAST) begin
              sck_q <= 1'b1;
              div_q <= '0;
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end else if (div_q == '0) begin
            // First high cycle: MISO has been stable since the preceding fall.
            if (state_q == S_DATA) begin
              rx_q <= rx_byte_d;
              if (bit_q == 5'd0) begin
                if (owner_q) begin
                  valid1_q <= 1'b1;
                  data1_q  <= rx_byte_d;
                end else begin
                  valid0_q <= 1'b1;
                  data0_q  <= rx_byte_d;
                end
                last_addr_q <= addr_q;
                sck_q       <= 1'b0;
                div_q       <= '0;
                tmr_q       <= '0;
                state_q     <= S_HOLD;
              end else begin
                div_q <= div_q + DIV_W'(1);
              end
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end else if (div_q == DIV_LAST) begin
            // Falling edge: shift out the next bit and advance the phase.
            sck_q  <= 1'b0;
            div_q  <= '0;
            mosi_q <= tx_q[30];
            tx_q   <= {tx_q[30:0], 1'b0};
            if (bit_q == 5'd0) begin
              case (state_q)
                S_CMD: begin
                  state_q <= S_ADDR;
                  bit_q   <= 5'd23;
                end
                S_ADDR: begin
                  state_q <= S_DATA;
                  bit_q   <= 5'd7;
                end
                default: begin
                  bit_q <= 5'd0;
                end
              endcase
            end else begin
              bit_q <= bit_q - 5'd1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_HOLD: begin
          cs_n_q <= 1'b0;
          sck_q  <= 1'b0;
          mosi_q <= 1'b0;
          if (seq_hit_d) begin
            ack0_q  <= !owner_q;
            ack1_q  <= owner_q;
            addr_q  <= owner_addr_d;
            tx_q    <= 32'd0;
            bit_q   <= 5'd7;
            div_q   <= '0;
            start_q <= 1'b1;
            state_q <= S_DATA;
          end else if (owner_req_d || other_req_d || (tmr_q == TMR_MAX)) begin
            cs_n_q   <= 1'b1;
            gap_q    <= '0;
            yield1_q <= !owner_q && bus.req1;
            state_q  <= S_DESEL;
          end else if (tmr_q != TMR_MAX) begin
            tmr_q <= tmr_q + TMR_W'(1);
          end else begin
            tmr_q <= tmr_q;
          end
        end

        S_DESEL: begin
          cs_n_q <= 1'b1;
          sck_q  <= 1'b0;
          mosi_q <= 1'b0;
          if (gap_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        default: begin
          cs_n_q  <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
          start_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
